load_store_unit: RTL

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/load_store_unit.sv
// Load/store unit: turns a memory-stage request into a single-beat bus access,
// handling byte-lane steering, alignment/legality faults and an ack timeout.
module load_store_unit #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned BIG_END = 1,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_load,
    input  logic            req_store,
    input  logic [2:0]      req_funct3,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    output logic            resp_valid,
    output logic [XLEN-1:0] resp_rdata,
    output logic            resp_misalign,
    output logic            resp_buserr,
    output logic            busy,
    output logic [XLEN-1:0] mem_addr,
    output logic            mem_rd,
    output logic            mem_wr,
    output logic [3:0]      mem_be,
    output logic [XLEN-1:0] mem_wdata,
    input  logic [XLEN-1:0] mem_rdata,
    input  logic            mem_ack
);

    localparam int unsigned     CNT_W    = 8;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t            state, state_n;
    logic [CNT_W-1:0]  wait_cnt;
    logic              lat_load;
    logic [2:0]        lat_funct3;
    logic [1:0]        lat_off;

    logic              accept, req_illegal, req_misalign, timeout_hit;
    logic [1:0]        req_lane, lat_lane;
    logic              req_hi_half, lat_hi_half;
    logic [3:0]        req_be;
    logic [XLEN-1:0]   req_lane_data, load_data, rdata_shift;
    logic [7:0]        load_byte;
    logic [15:0]       load_half;

    logic              rd_d, wr_d, valid_d, mis_d, err_d, busy_d, ready_d;
    logic [3:0]        be_d;
    logic [XLEN-1:0]   addr_d, wdata_d, rdata_d;

    // Request decode: legality, alignment, byte enables and lane-steered store data
    always_comb begin
        accept        = req_valid && (req_load || req_store);
        req_lane      = (BIG_END != 0) ? ~req_addr[1:0] : req_addr[1:0];
        req_hi_half   = (BIG_END != 0) ? ~req_addr[1] : req_addr[1];
        req_illegal   = 1'b0;
        req_misalign  = 1'b0;
        req_be        = 4'b1111;
        req_lane_data = req_wdata;
        if (req_load && req_store) begin
            req_illegal = 1'b1;
        end else if (req_load) begin
            req_illegal = (req_funct3 == 3'b011) || (req_funct3 == 3'b110) || (req_funct3 == 3'b111);
        end else if (req_store) begin
            req_illegal = (req_funct3 > 3'b010);
        end
        case (req_funct3[1:0])
            2'b00: begin
                req_be        = 4'b0001 << req_lane;
                req_lane_data = {24'h0, req_wdata[7:0]} << {req_lane, 3'b000};
            end
            2'b01: begin
                req_misalign  = req_addr[0];
                req_be        = req_hi_half ? 4'b1100 : 4'b0011;
                req_lane_data = req_hi_half ? {req_wdata[15:0], 16'h0} : {16'h0, req_wdata[15:0]};
            end
            2'b10: begin
                req_misalign  = |req_addr[1:0];
            end
            default: begin
                req_misalign  = 1'b0;
            end
        endcase
    end

    // Load data extraction from the returned word using the latched offset and size
    always_comb begin
        lat_lane    = (BIG_END != 0) ? ~lat_off : lat_off;
        lat_hi_half = (BIG_END != 0) ? ~lat_off[1] : lat_off[1];
        rdata_shift = mem_rdata >> {lat_lane, 3'b000};
        load_byte   = rdata_shift[7:0];
        load_half   = lat_hi_half ? mem_rdata[31:16] : mem_rdata[15:0];
        case (lat_funct3[1:0])
            2'b00:   load_data = {{24{~lat_funct3[2] & load_byte[7]}}, load_byte};
            2'b01:   load_data = {{16{~lat_funct3[2] & load_half[15]}}, load_half};
            default: load_data = mem_rdata;
        endcase
    end

    assign timeout_hit = (state == ACCESS) && !mem_ack && (wait_cnt == CNT_LAST);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    // Next-state logic
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (accept) state_n = (req_illegal || req_misalign) ? DONE : ACCESS;
            ACCESS:  if (mem_ack || timeout_hit) state_n = DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Output logic: next values for the registered outputs
    always_comb begin
        rd_d    = 1'b0;
        wr_d    = 1'b0;
        addr_d  = mem_addr;
        be_d    = mem_be;
        wdata_d = mem_wdata;
        rdata_d = '0;
        valid_d = (state_n == DONE);
        mis_d   = 1'b0;
        err_d   = 1'b0;
        busy_d  = (state_n != IDLE);
        ready_d = (state_n == IDLE);
        case (state)
            IDLE: begin
                if (accept) begin
                    if (state_n == ACCESS) begin
                        rd_d    = req_load;
                        wr_d    = req_store;
                        addr_d  = {req_addr[XLEN-1:2], 2'b00};
                        be_d    = req_be;
                        wdata_d = req_lane_data;
                    end else begin
                        err_d = req_illegal;
                        mis_d = ~req_illegal;
                    end
                end
            end
            ACCESS: begin
                if (state_n == ACCESS) begin
                    rd_d = lat_load;
                    wr_d = ~lat_load;
                end else if (mem_ack) begin
                    rdata_d = lat_load ? load_data : '0;
                end else begin
                    err_d = 1'b1;
                end
            end
            default: begin
                rd_d = 1'b0;
            end
        endcase
    end

    // Registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_rd        <= 1'b0;
            mem_wr        <= 1'b0;
            mem_addr      <= '0;
            mem_be        <= 4'b0000;
            mem_wdata     <= '0;
            resp_rdata    <= '0;
            resp_valid    <= 1'b0;
            resp_misalign <= 1'b0;
            resp_buserr   <= 1'b0;
            busy          <= 1'b0;
            req_ready     <= 1'b1;
        end else begin
            mem_rd        <= rd_d;
            mem_wr        <= wr_d;
            mem_addr      <= addr_d;
            mem_be        <= be_d;
            mem_wdata     <= wdata_d;
            resp_rdata    <= rdata_d;
            resp_valid    <= valid_d;
            resp_misalign <= mis_d;
            resp_buserr   <= err_d;
            busy          <= busy_d;
            req_ready     <= ready_d;
        end
    end

    // Request fields needed after acceptance
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lat_load   <= 1'b0;
            lat_funct3 <= 3'b000;
            lat_off    <= 2'b00;
        end else if (state == IDLE && accept) begin
            lat_load   <= req_load;
            lat_funct3 <= req_funct3;
            lat_off    <= req_addr[1:0];
        end
    end

    // Ack wait counter, zero whenever not in ACCESS
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)               wait_cnt <= '0;
        else if (state != ACCESS) wait_cnt <= '0;
        else if (!mem_ack)        wait_cnt <= wait_cnt + CNT_W'(1);
    end

endmodule
